data_cache: RTL and testbench
=============================

// Module: data_cache
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate L1 data cache between the
//  CPU memory stage and the byte-addressed backing data memory.
//  Load hits return data combinationally in the same cycle.
//  Misses and all stores stall the CPU while a word-wide req/ack port
//  refills a line or writes through.
// PARAMETERS
//  LINES       64  number of cache lines (power of 2)
//  LINE_WORDS  4   32-bit words per line (power of 2, >=2)
//  ADDR_W      32  CPU/memory address width
// PORTS
//  clk        in   1   sole clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  cpu_req    in   1   memory access valid this cycle
//  MemWrite   in   1   1=store, 0=load
//  SizeSrc    in   2   00=word, 01=half, 10=byte, 11=no access
//  LoadSign   in   1   1=sign-extend, 0=zero-extend (half/byte loads)
//  ALUResult  in   32  byte address
//  WriteData  in   32  store data, LSB-aligned
//  ReadData   out  32  extended load data
//  stall      out  1   CPU must hold all cpu_* inputs stable while high
//  misalign   out  1   access crosses a word boundary (comb); access dropped
//  mem_req    out  1   backing-memory request
//  mem_we     out  1   1=write
//  mem_addr   out  32  word-aligned address
//  mem_wdata  out  32  write data, byte lanes per mem_wstrb
//  mem_wstrb  out  4   byte-lane enables
//  mem_rdata  in   32  read data, valid with mem_ack
//  mem_ack    in   1   one-cycle completion pulse for current request
// BEHAVIOUR
//  Reset: all valid bits 0, state IDLE, mem_req/mem_we 0, beat count 0.
//   Outputs are then combinational: stall=0 and ReadData=0 unless cpu_req.
//  Address split: offset[1:0], word[log2 LINE_WORDS], index[log2 LINES], tag=rest.
//  misalign = cpu_req & ((half & a[0]) | (word & a[1:0]!=0)); with misalign
//   set: stall=0, ReadData=0, no state change, no memory traffic.
//  SizeSrc=11 or cpu_req=0: no access; stall=0, ReadData=0.
//  FSM IDLE/REFILL/WRITE:
//   IDLE, load hit: ReadData extended from cached word the same cycle, stall=0.
//   IDLE, load miss: stall=1. Line valid cleared, tag latched -> REFILL.
//   IDLE, store: stall=1. Latch addr/strobes/data -> WRITE.
//   REFILL: mem_req=1, mem_we=0, mem_addr=line base + 4*beat.
//    On each mem_ack: store mem_rdata into line word[beat], beat++.
//    On last ack: valid=1, beat=0 -> IDLE. The held load then hits next cycle.
//    stall=1 throughout REFILL.
//   WRITE: mem_req=1, mem_we=1, strobes/data byte-lane aligned: sb lane a[1:0], sh lanes {a[1],0}.
//    stall=!mem_ack; on ack: if tag hit and valid, update same bytes in the cache.
//    Then -> IDLE. The CPU advances on the ack cycle.
//  Handshake: mem_req and mem_addr/we/wdata/wstrb stay stable until mem_ack.
//   mem_ack while mem_req=0 is ignored. Only one request is outstanding.
//   Variable latency is allowed, including ack in the first request cycle.
//  Reset mid-REFILL: abort, line stays invalid (valid was cleared at start).
//  Reset mid-WRITE: store lost, no cache update.
// STRUCTURE
//  Package cache_pkg:
//   state_t enum {IDLE,REFILL,WRITE}.
//   Constants SIZE_WORD=2'b00, SIZE_HALF=2'b01, SIZE_BYTE=2'b10.
//  Sub-module load_extend: word + offset + SizeSrc + LoadSign -> ReadData (comb).
//  Tag/valid/data arrays are flops in data_cache; no SRAM macro.
// TESTING
//  lw 0x10000 cold -> stall, 4 reads at 0x10000..0x1000C, then hit, ReadData=mem word.
//  After fill, lb 0x10003 with byte 0x80, LoadSign=1 -> 0xFFFFFF80; LoadSign=0 -> 0x00000080.
//  sh 0x10002 data 0x1234 hit -> mem_wstrb=1100, wdata[31:16]=0x1234; lhu 0x10002 -> 0x00001234.
//  sw to 0x20000 (miss) -> one write, no fill; later lw 0x20000 refills, returns stored value.
//  mem_ack delayed 3 cycles per beat -> mem_addr stable; stall high exactly until fill ends.
//  rst_n low after 2nd refill beat -> mem_req=0 immediately; retried lw refetches all 4 beats.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the L1 data cache.
//  state_t     : controller state (IDLE / REFILL / WRITE)
//  SIZE_*      : SizeSrc encodings from the CPU memory stage
//  store_strb  : byte-lane enables for a store of a given size and offset
//  store_data  : store data replicated onto every lane it may occupy
package cache_pkg;

    localparam int unsigned DEF_LINES      = 64;
    localparam int unsigned DEF_LINE_WORDS = 4;
    localparam int unsigned DEF_ADDR_W     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_NONE = 2'b11;

    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] strb;
        case (size)
            SIZE_WORD: strb = 4'b1111;
            SIZE_HALF: strb = off[1] ? 4'b1100 : 4'b0011;
            SIZE_BYTE: strb = 4'b0001 << off;
            default:   strb = 4'b0000;
        endcase
        return strb;
    endfunction

    // Replicating the low bytes lets the strobe alone select the lane.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] data;
        case (size)
            SIZE_HALF: data = {2{wd[15:0]}};
            SIZE_BYTE: data = {4{wd[7:0]}};
            default:   data = wd;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half/word from a cached word and extends it.
//  word_i : 32-bit cached word
//  off_i  : byte offset within the word
//  size_i : SizeSrc encoding (no-access yields 0)
//  sign_i : 1 = sign-extend, 0 = zero-extend
//  data_o : extended load data
module load_extend
    import cache_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [15:0] half;
    logic [7:0]  byte_v;

    always_comb begin
        half = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (off_i)
            2'd0:    byte_v = word_i[7:0];
            2'd1:    byte_v = word_i[15:8];
            2'd2:    byte_v = word_i[23:16];
            default: byte_v = word_i[31:24];
        endcase
        case (size_i)
            SIZE_WORD: data_o = word_i;
            SIZE_HALF: data_o = {{16{sign_i & half[15]}}, half};
            SIZE_BYTE: data_o = {{24{sign_i & byte_v[7]}}, byte_v};
            default:   data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
//  CPU side : cpu_req/MemWrite/SizeSrc/LoadSign/ALUResult/WriteData in,
//             ReadData/stall/misalign out (combinational)
//  Mem side : mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb out,
//             mem_rdata/mem_ack in; single outstanding word request
module data_cache
    import cache_pkg::*;
#(
    parameter int unsigned LINES      = DEF_LINES,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              MemWrite,
    input  logic [1:0]        SizeSrc,
    input  logic              LoadSign,
    input  logic [ADDR_W-1:0] ALUResult,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              stall,
    output logic              misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned WORD_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - WORD_W - 2;

    // Address fields of the live CPU request and of the latched request.
    logic [WORD_W-1:0] cpu_word, q_word;
    logic [IDX_W-1:0]  cpu_idx,  q_idx;
    logic [TAG_W-1:0]  cpu_tag,  q_tag;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  beat_q,  beat_d;
    logic [ADDR_W-3:0]  addr_q,  addr_d;
    logic [3:0]         strb_q,  strb_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [LINES-1:0]   valid_q, valid_d;

    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES][LINE_WORDS];

    logic        access, hit, miss_start, fill_we, wr_upd;
    logic [31:0] ext_data;

    assign cpu_word = ALUResult[2 +: WORD_W];
    assign cpu_idx  = ALUResult[2+WORD_W +: IDX_W];
    assign cpu_tag  = ALUResult[ADDR_W-1 -: TAG_W];
    assign q_word   = addr_q[0 +: WORD_W];
    assign q_idx    = addr_q[WORD_W +: IDX_W];
    assign q_tag    = addr_q[ADDR_W-3 -: TAG_W];

    assign misalign = cpu_req & (((SizeSrc == SIZE_HALF) & ALUResult[0]) |
                                 ((SizeSrc == SIZE_WORD) & (ALUResult[1:0] != 2'b00)));
    assign access   = cpu_req & (SizeSrc != SIZE_NONE) & ~misalign;
    assign hit      = valid_q[cpu_idx] & (tag_q[cpu_idx] == cpu_tag);

    load_extend u_load_extend (
        .word_i (data_q[cpu_idx][cpu_word]),
        .off_i  (ALUResult[1:0]),
        .size_i (SizeSrc),
        .sign_i (LoadSign),
        .data_o (ext_data)
    );

    // Memory port is a pure decode of registered state.
    assign mem_req   = (state_q != IDLE);
    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = (state_q == REFILL) ? {addr_q[ADDR_W-3:WORD_W], beat_q, 2'b00}
                                           : {addr_q, 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_wstrb = (state_q == WRITE) ? strb_q : 4'b0000;

    // Next-state, CPU-side outputs and array write enables.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        addr_d     = addr_q;
        strb_d     = strb_q;
        wdata_d    = wdata_q;
        valid_d    = valid_q;
        stall      = 1'b0;
        ReadData   = 32'h0;
        miss_start = 1'b0;
        fill_we    = 1'b0;
        wr_upd     = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (MemWrite) begin
                        stall   = 1'b1;
                        addr_d  = ALUResult[ADDR_W-1:2];
                        strb_d  = store_strb(SizeSrc, ALUResult[1:0]);
                        wdata_d = store_data(SizeSrc, WriteData);
                        state_d = WRITE;
                    end else if (hit) begin
                        ReadData = ext_data;
                    end else begin
                        // Invalidate now so an aborted refill leaves no stale line.
                        stall            = 1'b1;
                        miss_start       = 1'b1;
                        valid_d[cpu_idx] = 1'b0;
                        addr_d           = ALUResult[ADDR_W-1:2];
                        beat_d           = '0;
                        state_d          = REFILL;
                    end
                end
            end
            REFILL: begin
                stall = 1'b1;
                if (mem_ack) begin
                    fill_we = 1'b1;
                    beat_d  = beat_q + WORD_W'(1);
                    if (beat_q == WORD_W'(LINE_WORDS - 1)) begin
                        valid_d[q_idx] = 1'b1;
                        beat_d         = '0;
                        state_d        = IDLE;
                    end
                end
            end
            WRITE: begin
                stall = ~mem_ack;
                if (mem_ack) begin
                    wr_upd  = valid_q[q_idx] & (tag_q[q_idx] == q_tag);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (miss_start) tag_q[cpu_idx] <= cpu_tag;
        if (fill_we)    data_q[q_idx][beat_q] <= mem_rdata;
        for (int b = 0; b < 4; b++) begin
            if (wr_upd && strb_q[b]) data_q[q_idx][q_word][8*b +: 8] <= wdata_q[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, MemWrite, LoadSign;
    logic [1:0]  SizeSrc;
    logic [31:0] ALUResult, WriteData, ReadData;
    logic        stall, misalign;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int checks   = 0;
    int failures = 0;

    data_cache dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .MemWrite(MemWrite),
        .SizeSrc(SizeSrc), .LoadSign(LoadSign), .ALUResult(ALUResult),
        .WriteData(WriteData), .ReadData(ReadData), .stall(stall),
        .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Backing memory model: word-addressed, responds after lat wait cycles.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_log [$];
    int          lat = 0;
    int          wait_cnt = 0;
    int          n_reads = 0, n_writes = 0, addr_unstable = 0;
    logic [31:0] held_addr = '0, last_waddr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;

    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (!rst_n || !mem_req) begin
            wait_cnt = 0;
        end else begin
            if (wait_cnt > 0 && mem_addr !== held_addr) addr_unstable++;
            held_addr = mem_addr;
            if (wait_cnt >= lat) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (mem_we) begin
                    logic [31:0] w;
                    w = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                    mem[mem_addr] = w;
                    last_waddr = mem_addr;
                    last_wdata = mem_wdata;
                    last_wstrb = mem_wstrb;
                    n_writes++;
                end else begin
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                    rd_log.push_back(mem_addr);
                    n_reads++;
                end
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // One CPU access: inputs held until stall drops, CPU advances on that edge.
    task automatic access(input logic we, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int cyc, output logic mis);
        @(negedge clk);
        cpu_req = 1'b1; MemWrite = we; SizeSrc = sz; LoadSign = sgn;
        ALUResult = a; WriteData = wd;
        cyc = 0;
        #1;
        mis = misalign;
        while (stall && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("no_hang", 32'(stall), 32'h0);
        rd = ReadData;
        @(posedge clk);
        #1 cpu_req = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_cyc;
        logic        exp_mis;
        int          exp_nr;
        int          exp_nw;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    function automatic vec_t mk(string n, logic we, logic [1:0] sz, logic sgn,
                                logic [31:0] a, logic [31:0] wd, logic [31:0] rd,
                                int cyc, logic mis, int nr, int nw,
                                logic [3:0] strb, logic [31:0] wdat);
        vec_t v;
        v.name = n; v.we = we; v.sz = sz; v.sgn = sgn; v.addr = a; v.wd = wd;
        v.exp_rd = rd; v.exp_cyc = cyc; v.exp_mis = mis; v.exp_nr = nr; v.exp_nw = nw;
        v.exp_strb = strb; v.exp_wdata = wdat;
        return v;
    endfunction

    initial begin
        vec_t        vecs [$];
        logic [31:0] rd, mask;
        int          cyc, nr0, nw0;
        logic        mis;

        mem[32'h10000] = 32'h80332211;
        mem[32'h10004] = 32'hDEADBEEF;
        mem[32'h10008] = 32'h00007FFF;
        mem[32'h1000C] = 32'hCAFEF00D;
        mem[32'h30004] = 32'h0BADF00D;
        mem[32'h40008] = 32'h76543210;

        // Loads at lat=0: a miss stalls 1 + 4 beats; hits stall 0.
        vecs.push_back(mk("lw_cold",     0, SIZE_WORD, 0, 32'h10000, 0, 32'h80332211, 5, 0, 4, 0, 0, 0));
        vecs.push_back(mk("lw_hit",      0, SIZE_WORD, 0, 32'h10004, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lb_sign",     0, SIZE_BYTE, 1, 32'h10003, 0, 32'hFFFFFF80, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lbu",         0, SIZE_BYTE, 0, 32'h10003, 0, 32'h00000080, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lh_sign_hi",  0, SIZE_HALF, 1, 32'h1000E, 0, 32'hFFFFCAFE, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lhu_lo",      0, SIZE_HALF, 0, 32'h1000C, 0, 32'h0000F00D, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lb_pos",      0, SIZE_BYTE, 1, 32'h10001, 0, 32'h00000022, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sh_hit",      1, SIZE_HALF, 0, 32'h10002, 32'h00001234, 0, 1, 0, 0, 1, 4'b1100, 32'h12340000));
        vecs.push_back(mk("lhu_after_sh",0, SIZE_HALF, 0, 32'h10002, 0, 32'h00001234, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lw_after_sh", 0, SIZE_WORD, 0, 32'h10000, 0, 32'h12342211, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sb_hit",      1, SIZE_BYTE, 0, 32'h10001, 32'hFFFFFFAB, 0, 1, 0, 0, 1, 4'b0010, 32'h0000AB00));
        vecs.push_back(mk("lw_after_sb", 0, SIZE_WORD, 0, 32'h10000, 0, 32'h1234AB11, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sw_miss",     1, SIZE_WORD, 0, 32'h20000, 32'h55AA1234, 0, 1, 0, 0, 1, 4'b1111, 32'h55AA1234));
        vecs.push_back(mk("lw_sw_fill",  0, SIZE_WORD, 0, 32'h20000, 0, 32'h55AA1234, 5, 0, 4, 0, 0, 0));
        vecs.push_back(mk("lw_evicted",  0, SIZE_WORD, 0, 32'h10000, 0, 32'h1234AB11, 5, 0, 4, 0, 0, 0));
        vecs.push_back(mk("no_access",   0, SIZE_NONE, 0, 32'h10000, 0, 32'h0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lw_misalign", 0, SIZE_WORD, 0, 32'h10002, 0, 32'h0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("sh_misalign", 1, SIZE_HALF, 0, 32'h10001, 32'h5555, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("sw_none",     1, SIZE_NONE, 0, 32'h10000, 32'h5555, 0, 0, 0, 0, 0, 0, 0));

        cpu_req = 0; MemWrite = 0; SizeSrc = SIZE_WORD; LoadSign = 0;
        ALUResult = 0; WriteData = 0; mem_ack = 0; mem_rdata = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall",    32'(stall),   32'h0);
        chk("rst_mem_req",  32'(mem_req), 32'h0);
        chk("rst_mem_we",   32'(mem_we),  32'h0);
        chk("rst_readdata", ReadData,     32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            nr0 = n_reads; nw0 = n_writes;
            access(vecs[i].we, vecs[i].sz, vecs[i].sgn, vecs[i].addr, vecs[i].wd, rd, cyc, mis);
            chk({vecs[i].name, "_rd"},    rd,                   vecs[i].exp_rd);
            chk({vecs[i].name, "_stall"}, 32'(cyc),             32'(vecs[i].exp_cyc));
            chk({vecs[i].name, "_mis"},   32'(mis),             32'(vecs[i].exp_mis));
            chk({vecs[i].name, "_reads"}, 32'(n_reads - nr0),   32'(vecs[i].exp_nr));
            chk({vecs[i].name, "_writes"},32'(n_writes - nw0),  32'(vecs[i].exp_nw));
            if (vecs[i].exp_nw != 0) begin
                for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{vecs[i].exp_strb[b]}};
                chk({vecs[i].name, "_wstrb"}, 32'(last_wstrb), 32'(vecs[i].exp_strb));
                chk({vecs[i].name, "_wdata"}, last_wdata & mask, vecs[i].exp_wdata);
                chk({vecs[i].name, "_waddr"}, last_waddr, vecs[i].addr & 32'hFFFF_FFFC);
            end
        end
        chk("cold_fill_a0", rd_log[0], 32'h10000);
        chk("cold_fill_a1", rd_log[1], 32'h10004);
        chk("cold_fill_a2", rd_log[2], 32'h10008);
        chk("cold_fill_a3", rd_log[3], 32'h1000C);

        // Slow memory: 3 wait cycles per beat.
        lat = 3;
        nr0 = n_reads;
        access(0, SIZE_WORD, 0, 32'h30004, 0, rd, cyc, mis);
        chk("slow_lw_rd",    rd,               32'h0BADF00D);
        chk("slow_lw_stall", 32'(cyc),         32'd17);
        chk("slow_lw_reads", 32'(n_reads-nr0), 32'd4);
        for (int k = 0; k < 4; k++)
            chk("slow_fill_addr", rd_log[nr0 + k], 32'h30000 + 32'(4 * k));
        chk("addr_stable", 32'(addr_unstable), 32'h0);
        nw0 = n_writes;
        access(1, SIZE_WORD, 0, 32'h30008, 32'h11112222, rd, cyc, mis);
        chk("slow_sw_stall",  32'(cyc),          32'd4);
        chk("slow_sw_writes", 32'(n_writes-nw0), 32'd1);
        lat = 0;
        nr0 = n_reads;
        access(0, SIZE_WORD, 0, 32'h30008, 0, rd, cyc, mis);
        chk("sw_update_rd",    rd,               32'h11112222);
        chk("sw_update_stall", 32'(cyc),         32'd0);
        chk("sw_update_reads", 32'(n_reads-nr0), 32'd0);

        // Reset after the second refill beat aborts the fill.
        nr0 = n_reads;
        @(negedge clk);
        cpu_req = 1; MemWrite = 0; SizeSrc = SIZE_WORD; LoadSign = 0; ALUResult = 32'h40008;
        for (int k = 0; k < 50 && n_reads < nr0 + 2; k++) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", 32'(mem_req),         32'h0);
        chk("rst_mid_reads",   32'(n_reads - nr0),   32'd2);
        @(negedge clk);
        cpu_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        nr0 = n_reads;
        access(0, SIZE_WORD, 0, 32'h40008, 0, rd, cyc, mis);
        chk("retry_rd",    rd,               32'h76543210);
        chk("retry_stall", 32'(cyc),         32'd5);
        chk("retry_reads", 32'(n_reads-nr0), 32'd4);
        chk("retry_first", rd_log[nr0],      32'h40000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
